t5_wback: RTL and testbench
===========================

Name: t5_wback

Overview:
- Parametrised writeback/memory-return stage of the t5 pipeline; successor to the fixed 32-bit back end.
- Registers the X-stage result into an M stage and aligns and extends load data by byte offset and funct3, for XLEN 32 or 64.
- Selects the register-file write data from the load data, the ALU result, or the link address (pc+4).
- Handles wait-stated data-bus loads with a stall output, a bus timeout, and misalignment detection.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TMO, 15, maximum wait cycles for dwb_ack before a bus error; legal range 1..255.

Ports:
- sclk  in  1  clock.
- srst  in  1  reset; synchronous, active-high.
- sena  in  1  global pipeline enable.
- xopc  in  5  X-stage opcode, bits [6:2].
- xfn3  in  3  X-stage funct3, bits [14:12].
- xrd  in  5  X-stage destination register.
- xoff  in  log2(XLEN/8)  X-stage byte offset, taken from the low address bits.
- xstb  in  1  X-stage data-bus strobe.
- xwre  in  1  X-stage data-bus write (1 = store).
- xalu  in  XLEN  X-stage ALU result.
- xpc  in  XLEN  X-stage pc.
- dwb_dti  in  XLEN  data-bus read data.
- dwb_ack  in  1  data-bus acknowledge.
- rd0d  out  XLEN  register-file write data.
- rd0a  out  5  register-file write address.
- rd0e  out  1  register-file write enable.
- xstall  out  1  hold request to the upstream pipeline.
- berr  out  1  one-cycle bus-timeout pulse.
- malign  out  1  one-cycle misaligned-load pulse.

Behaviour:
- Internal advance: adv = sena & !xstall.
- xstall is combinational: xstb & !dwb_ack & sena & state==WAIT_OR_IDLE & !timeout.
  - A zero-wait ack in the request cycle therefore produces no stall.
- FSM, two states:
  - IDLE. If sena & xstb & !dwb_ack, go to WAIT and set cnt=1.
  - WAIT. Each cycle with sena=1, increment cnt.
    - On dwb_ack, return to IDLE.
    - When cnt==TMO without an ack, force timeout: berr=1 for one cycle, xstall drops this cycle, return to IDLE.
    - When sena=0, hold state and cnt.
- M register (mopc, mfn3, moff, mrd, malu, mpc, mdat, mval, mbad) captures the X-stage values on adv.
  - When sena=1 and xstall=1, load a bubble: mval=0, all else held.
  - When sena=0, hold everything.
- Load data is captured into mdat on adv when xstb & !xwre, from the dwb_dti value present that cycle; on a timeout the data is don't-care and mbad=1.
- Load extension, by xfn3:
  - 000 LB, 100 LBU: lane xoff.
  - 001 LH, 101 LHU: lane xoff[..1].
  - 010 LW, 110 LWU: word xoff[..2].
  - 011 LD: XLEN=64 only.
  - Signed forms sign-extend from the lane's MSB; unsigned forms zero-fill.
  - funct3 011 or 110 with XLEN=32, and 111, are illegal: treat as misaligned.
- Misalignment: a halfword with odd offset, a word with offset[1:0]!=0, or a double with offset!=0.
  - Sets mbad and pulses malign in the cycle the load enters M.
- Writeback select, on mopc:
  - 00000 (load): extended mdat.
  - 11011 (JAL), 11001 (JALR): mpc+4, computed in XLEN bits with wrap-around.
  - Otherwise: malu.
- rd0a = mrd.
- rd0e = mval & |mrd & !mbad & mopc not 01000 (store) & mopc not 11000 (branch); one cycle per instruction.
- Stores never stall beyond their ack; a store that times out pulses berr with no write.
- Reset values:
  - state IDLE, cnt 0.
  - mopc 5'h0D, mval 0, mrd 0, mbad 0, mdat 0, malu 0, mpc 0.
  - Outputs: rd0e 0, berr 0, malign 0; rd0d = malu = 0.
- Reset mid-WAIT aborts the wait: no berr, no write, xstall=0 in the following cycle.
- Simultaneous ack and timeout in the same cycle: the ack wins; no berr.

Test Plan:
- XLEN=32: LB, xoff=2, dwb_dti=32'h1280_0000, zero-wait ack -> next cycle rd0d=32'hFFFF_FF80, rd0e=1, xstall never asserted.
- XLEN=64: LWU, xoff=4, dwb_dti=64'h8765_4321_0000_0000 -> rd0d=64'h0000_0000_8765_4321; LW, same data -> 64'hFFFF_FFFF_8765_4321.
- Load acked 3 cycles late -> xstall high exactly 3 cycles, bubbles with rd0e=0 during the stall, a single rd0e pulse with the correct data.
- TMO=4, no ack -> xstall high 4 cycles, then berr=1 for one cycle, no rd0e for that load, the pipeline resumes.
- JAL, xpc=32'hFFFF_FFFC, xrd=1 -> rd0d=0, rd0e=1; store or branch with xrd=5 -> rd0e=0; ALU op with xrd=0 -> rd0e=0.
- LH, xoff=1 -> malign pulse, rd0e=0; srst asserted mid-WAIT -> state IDLE, xstall=0, rd0e=0, berr=0.

Source files
------------

// File: rtl/t5_wback.sv
// t5_wback: writeback / memory-return stage of the t5 pipeline.
//
// Registers the X-stage result into an M stage, aligns and sign/zero-extends
// load data by byte offset and funct3, and selects the register-file write
// data (load data, ALU result or link address pc+4). Wait-stated data-bus
// loads and stores hold the upstream pipeline through xstall until dwb_ack
// arrives or the wait counter reaches TMO, in which case berr pulses.
//
// Ports:
//   sclk, srst        clock, synchronous active-high reset
//   sena              global pipeline enable
//   xopc/xfn3/xrd     X-stage opcode[6:2], funct3, destination register
//   xoff              X-stage byte offset (low address bits)
//   xstb/xwre         X-stage data-bus strobe / write
//   xalu/xpc          X-stage ALU result / pc
//   dwb_dti/dwb_ack   data-bus read data / acknowledge
//   rd0d/rd0a/rd0e    register-file write data / address / enable
//   xstall            hold request to upstream
//   berr              one-cycle bus-timeout pulse
//   malign            one-cycle misaligned-load pulse
module t5_wback #(
    parameter int XLEN = 32,
    parameter int TMO  = 15
) (
    input  logic                         sclk,
    input  logic                         srst,
    input  logic                         sena,
    input  logic [4:0]                   xopc,
    input  logic [2:0]                   xfn3,
    input  logic [4:0]                   xrd,
    input  logic [$clog2(XLEN/8)-1:0]    xoff,
    input  logic                         xstb,
    input  logic                         xwre,
    input  logic [XLEN-1:0]              xalu,
    input  logic [XLEN-1:0]              xpc,
    input  logic [XLEN-1:0]              dwb_dti,
    input  logic                         dwb_ack,
    output logic [XLEN-1:0]              rd0d,
    output logic [4:0]                   rd0a,
    output logic                         rd0e,
    output logic                         xstall,
    output logic                         berr,
    output logic                         malign
);

    localparam int OW = $clog2(XLEN/8);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q;
    logic [7:0]      cnt_q;

    logic [4:0]      mopc_q;
    logic [2:0]      mfn3_q;
    logic [OW-1:0]   moff_q;
    logic [4:0]      mrd_q;
    logic [XLEN-1:0] malu_q;
    logic [XLEN-1:0] mpc_q;
    logic [XLEN-1:0] mdat_q;
    logic            mval_q;
    logic            mbad_q;
    logic            malign_q;

    logic            timeout;
    logic            adv;
    logic            is_load;
    logic            mis;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] ext;

    // The ack wins over a timeout landing in the same cycle.
    assign timeout = sena & (state_q == S_WAIT) & (cnt_q == 8'(TMO)) & ~dwb_ack;
    assign xstall  = xstb & ~dwb_ack & sena & ~timeout;
    assign adv     = sena & ~xstall;
    assign berr    = timeout;
    assign is_load = xstb & ~xwre;

    // Encodings not supported at this XLEN are folded into misalignment.
    always_comb begin
        mis = 1'b0;
        case (xfn3)
            3'b000, 3'b100: mis = 1'b0;
            3'b001, 3'b101: mis = xoff[0];
            3'b010:         mis = |xoff[1:0];
            3'b110:         mis = (XLEN == 32) ? 1'b1 : |xoff[1:0];
            3'b011:         mis = (XLEN == 32) ? 1'b1 : |xoff;
            default:        mis = 1'b1;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else if (sena) begin
            case (state_q)
                S_IDLE: begin
                    if (xstb && !dwb_ack) begin
                        state_q <= S_WAIT;
                        cnt_q   <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (dwb_ack || timeout) begin
                        state_q <= S_IDLE;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            mopc_q   <= 5'h0D;
            mfn3_q   <= 3'd0;
            moff_q   <= '0;
            mrd_q    <= 5'd0;
            malu_q   <= '0;
            mpc_q    <= '0;
            mdat_q   <= '0;
            mval_q   <= 1'b0;
            mbad_q   <= 1'b0;
            malign_q <= 1'b0;
        end else begin
            malign_q <= 1'b0;
            if (adv) begin
                mopc_q   <= xopc;
                mfn3_q   <= xfn3;
                moff_q   <= xoff;
                mrd_q    <= xrd;
                malu_q   <= xalu;
                mpc_q    <= xpc;
                mval_q   <= 1'b1;
                mbad_q   <= timeout | (is_load & mis);
                malign_q <= is_load & mis;
                if (is_load) begin
                    mdat_q <= dwb_dti;
                end
            end else if (sena) begin
                // Stalled: push a bubble so the held instruction writes only once.
                mval_q <= 1'b0;
            end
        end
    end

    // Aligned accesses have zero low offset bits, so one shift serves every size.
    assign sh = mdat_q >> {moff_q, 3'b000};

    always_comb begin
        ext = sh;
        case (mfn3_q)
            3'b000:  ext = XLEN'($signed(sh[7:0]));
            3'b100:  ext = XLEN'(sh[7:0]);
            3'b001:  ext = XLEN'($signed(sh[15:0]));
            3'b101:  ext = XLEN'(sh[15:0]);
            3'b010:  ext = XLEN'($signed(sh[31:0]));
            3'b110:  ext = XLEN'(sh[31:0]);
            default: ext = sh;
        endcase
    end

    always_comb begin
        rd0d = malu_q;
        case (mopc_q)
            OPC_LOAD:          rd0d = ext;
            OPC_JAL, OPC_JALR: rd0d = mpc_q + XLEN'(4);
            default:           rd0d = malu_q;
        endcase
    end

    // Gating with sena means a valid M entry writes in exactly one cycle: the
    // first enabled cycle, after which it is replaced by the next entry or a bubble.
    assign rd0a   = mrd_q;
    assign rd0e   = sena & mval_q & (|mrd_q) & ~mbad_q &
                    (mopc_q != OPC_STORE) & (mopc_q != OPC_BRANCH);
    assign malign = malign_q;

endmodule

// File: tb/tb_t5_wback.sv
module tb_t5_wback;

    logic sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic        srst, sena, xstb, xwre, dwb_ack;
    logic [4:0]  xopc, xrd;
    logic [2:0]  xfn3;

    logic [2:0]  off64;
    logic [63:0] alu64, pc64, dti64, d64;
    logic [4:0]  a64;
    logic        e64, st64, be64, ma64;

    logic [1:0]  off32;
    logic [31:0] alu32, pc32, dti32, d32;
    logic [4:0]  a32;
    logic        e32, st32, be32, ma32;

    t5_wback #(.XLEN(64), .TMO(4)) u64 (
        .sclk(sclk), .srst(srst), .sena(sena), .xopc(xopc), .xfn3(xfn3),
        .xrd(xrd), .xoff(off64), .xstb(xstb), .xwre(xwre), .xalu(alu64),
        .xpc(pc64), .dwb_dti(dti64), .dwb_ack(dwb_ack), .rd0d(d64),
        .rd0a(a64), .rd0e(e64), .xstall(st64), .berr(be64), .malign(ma64)
    );

    t5_wback #(.XLEN(32), .TMO(4)) u32 (
        .sclk(sclk), .srst(srst), .sena(sena), .xopc(xopc), .xfn3(xfn3),
        .xrd(xrd), .xoff(off32), .xstb(xstb), .xwre(xwre), .xalu(alu32),
        .xpc(pc32), .dwb_dti(dti32), .dwb_ack(dwb_ack), .rd0d(d32),
        .rd0a(a32), .rd0e(e32), .xstall(st32), .berr(be32), .malign(ma32)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic ctl(input logic [4:0] opc, input logic [2:0] fn3, input logic [4:0] rd,
                       input logic stb, input logic wre, input logic ack);
        xopc = opc; xfn3 = fn3; xrd = rd; xstb = stb; xwre = wre; dwb_ack = ack;
    endtask

    task automatic idle();
        ctl(5'b01100, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [4:0]  opc;
        logic [2:0]  fn3;
        logic [4:0]  rd;
        logic [2:0]  off;
        logic        stb;
        logic        wre;
        logic [63:0] alu;
        logic [63:0] pc;
        logic [63:0] dti;
        logic [63:0] exp_d;
        logic        chk_d;
        logic        exp_e;
        logic        exp_m;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] opc, input logic [2:0] fn3, input logic [4:0] rd,
                                input logic [2:0] off, input logic stb, input logic wre,
                                input logic [63:0] alu, input logic [63:0] pc, input logic [63:0] dti,
                                input logic [63:0] exp_d, input logic chk_d, input logic exp_e,
                                input logic exp_m);
        vec_t v;
        v.opc = opc; v.fn3 = fn3; v.rd = rd; v.off = off; v.stb = stb; v.wre = wre;
        v.alu = alu; v.pc = pc; v.dti = dti; v.exp_d = exp_d; v.chk_d = chk_d;
        v.exp_e = exp_e; v.exp_m = exp_m;
        return v;
    endfunction

    vec_t vt[19];

    initial begin
        vt[0]  = mk(5'b00000, 3'b110, 5'd3,  3'd4, 1, 0, 64'h0, 64'h0, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 1, 1, 0);
        vt[1]  = mk(5'b00000, 3'b010, 5'd3,  3'd4, 1, 0, 64'h0, 64'h0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 1, 1, 0);
        vt[2]  = mk(5'b00000, 3'b011, 5'd4,  3'd0, 1, 0, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1, 1, 0);
        vt[3]  = mk(5'b00000, 3'b001, 5'd5,  3'd6, 1, 0, 64'h0, 64'h0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001, 1, 1, 0);
        vt[4]  = mk(5'b00000, 3'b101, 5'd5,  3'd6, 1, 0, 64'h0, 64'h0, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001, 1, 1, 0);
        vt[5]  = mk(5'b00000, 3'b100, 5'd6,  3'd7, 1, 0, 64'h0, 64'h0, 64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5, 1, 1, 0);
        vt[6]  = mk(5'b00000, 3'b000, 5'd7,  3'd0, 1, 0, 64'h0, 64'h0, 64'h0000_0000_0000_007F, 64'h0000_0000_0000_007F, 1, 1, 0);
        vt[7]  = mk(5'b00000, 3'b000, 5'd7,  3'd5, 1, 0, 64'h0, 64'h0, 64'h0000_FE00_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1, 0);
        vt[8]  = mk(5'b00000, 3'b001, 5'd8,  3'd1, 1, 0, 64'h0, 64'h0, 64'h1111_2222_3333_4444, 64'h0, 0, 0, 1);
        vt[9]  = mk(5'b00000, 3'b010, 5'd8,  3'd2, 1, 0, 64'h0, 64'h0, 64'h1111_2222_3333_4444, 64'h0, 0, 0, 1);
        vt[10] = mk(5'b00000, 3'b011, 5'd8,  3'd4, 1, 0, 64'h0, 64'h0, 64'h1111_2222_3333_4444, 64'h0, 0, 0, 1);
        vt[11] = mk(5'b00000, 3'b111, 5'd8,  3'd0, 1, 0, 64'h0, 64'h0, 64'h1111_2222_3333_4444, 64'h0, 0, 0, 1);
        vt[12] = mk(5'b01100, 3'b000, 5'd7,  3'd0, 0, 0, 64'h1234, 64'h0, 64'h0, 64'h1234, 1, 1, 0);
        vt[13] = mk(5'b01100, 3'b000, 5'd0,  3'd0, 0, 0, 64'h55, 64'h0, 64'h0, 64'h55, 1, 0, 0);
        vt[14] = mk(5'b01000, 3'b010, 5'd5,  3'd0, 1, 1, 64'h99, 64'h0, 64'h0, 64'h99, 1, 0, 0);
        vt[15] = mk(5'b11000, 3'b000, 5'd5,  3'd0, 0, 0, 64'h1, 64'h0, 64'h0, 64'h1, 1, 0, 0);
        vt[16] = mk(5'b11001, 3'b000, 5'd1,  3'd0, 0, 0, 64'hABC, 64'h1000, 64'h0, 64'h1004, 1, 1, 0);
        vt[17] = mk(5'b11011, 3'b000, 5'd31, 3'd0, 0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 1, 1, 0);
        vt[18] = mk(5'b01101, 3'b000, 5'd2,  3'd0, 0, 0, 64'hDEAD, 64'h0, 64'h0, 64'hDEAD, 1, 1, 0);

        srst = 1'b1; sena = 1'b1; idle();
        off64 = '0; alu64 = '0; pc64 = '0; dti64 = '0;
        off32 = '0; alu32 = '0; pc32 = '0; dti32 = '0;

        // Reset state
        repeat (2) @(posedge sclk);
        #1;
        chk("rst_d64", d64, 64'h0);
        chk("rst_e64", {63'h0, e64}, 64'h0);
        chk("rst_a64", {59'h0, a64}, 64'h0);
        chk("rst_be64", {63'h0, be64}, 64'h0);
        chk("rst_ma64", {63'h0, ma64}, 64'h0);
        chk("rst_st64", {63'h0, st64}, 64'h0);
        chk("rst_d32", {32'h0, d32}, 64'h0);
        chk("rst_e32", {63'h0, e32}, 64'h0);
        @(negedge sclk);
        srst = 1'b0;

        // Single-cycle table, zero-wait bus
        for (int i = 0; i < 19; i++) begin
            @(negedge sclk);
            ctl(vt[i].opc, vt[i].fn3, vt[i].rd, vt[i].stb, vt[i].wre, vt[i].stb);
            off64 = vt[i].off; alu64 = vt[i].alu; pc64 = vt[i].pc; dti64 = vt[i].dti;
            off32 = vt[i].off[1:0]; alu32 = vt[i].alu[31:0]; pc32 = vt[i].pc[31:0];
            dti32 = vt[i].dti[31:0];
            #1;
            chk($sformatf("v%0d_stall", i), {63'h0, st64}, 64'h0);
            @(posedge sclk);
            #1;
            chk($sformatf("v%0d_e", i), {63'h0, e64}, {63'h0, vt[i].exp_e});
            chk($sformatf("v%0d_a", i), {59'h0, a64}, {59'h0, vt[i].rd});
            chk($sformatf("v%0d_mal", i), {63'h0, ma64}, {63'h0, vt[i].exp_m});
            if (vt[i].chk_d) chk($sformatf("v%0d_d", i), d64, vt[i].exp_d);
        end

        // XLEN=32 LB with zero-wait ack
        @(negedge sclk);
        ctl(5'b00000, 3'b000, 5'd4, 1'b1, 1'b0, 1'b1);
        off32 = 2'd2; dti32 = 32'h1280_0000;
        #1;
        chk("lb32_stall", {63'h0, st32}, 64'h0);
        @(posedge sclk);
        #1;
        chk("lb32_d", {32'h0, d32}, {32'h0, 32'hFFFF_FF80});
        chk("lb32_e", {63'h0, e32}, 64'h1);

        // XLEN=32 JAL wrap
        @(negedge sclk);
        ctl(5'b11011, 3'b000, 5'd1, 1'b0, 1'b0, 1'b0);
        pc32 = 32'hFFFF_FFFC;
        @(posedge sclk);
        #1;
        chk("jal32_d", {32'h0, d32}, 64'h0);
        chk("jal32_e", {63'h0, e32}, 64'h1);

        // XLEN=32 LH odd offset
        @(negedge sclk);
        ctl(5'b00000, 3'b001, 5'd6, 1'b1, 1'b0, 1'b1);
        off32 = 2'd1;
        @(posedge sclk);
        #1;
        chk("lh32_mal", {63'h0, ma32}, 64'h1);
        chk("lh32_e", {63'h0, e32}, 64'h0);
        @(negedge sclk);
        idle();
        @(posedge sclk);
        #1;
        chk("lh32_mal_end", {63'h0, ma32}, 64'h0);

        // Load acked three cycles late
        for (int k = 0; k < 4; k++) begin
            @(negedge sclk);
            if (k == 0) begin
                ctl(5'b00000, 3'b010, 5'd9, 1'b1, 1'b0, 1'b0);
                off64 = 3'd0; dti64 = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            if (k == 3) begin
                dwb_ack = 1'b1; dti64 = 64'h0000_0000_C000_0001;
            end
            #1;
            chk($sformatf("late_stall%0d", k), {63'h0, st64}, {63'h0, (k < 3)});
            @(posedge sclk);
            #1;
            chk($sformatf("late_e%0d", k), {63'h0, e64}, {63'h0, (k == 3)});
        end
        chk("late_d", d64, 64'hFFFF_FFFF_C000_0001);
        @(negedge sclk);
        idle();
        @(posedge sclk);
        #1;
        chk("late_single", {63'h0, e64}, 64'h0);

        // Load times out (TMO=4), then pipeline resumes
        for (int k = 0; k < 5; k++) begin
            @(negedge sclk);
            if (k == 0) ctl(5'b00000, 3'b010, 5'd10, 1'b1, 1'b0, 1'b0);
            #1;
            chk($sformatf("tmo_stall%0d", k), {63'h0, st64}, {63'h0, (k < 4)});
            chk($sformatf("tmo_berr%0d", k), {63'h0, be64}, {63'h0, (k == 4)});
            @(posedge sclk);
            #1;
            chk($sformatf("tmo_e%0d", k), {63'h0, e64}, 64'h0);
        end
        @(negedge sclk);
        ctl(5'b01100, 3'b000, 5'd11, 1'b0, 1'b0, 1'b0);
        alu64 = 64'h77;
        #1;
        chk("tmo_berr_end", {63'h0, be64}, 64'h0);
        @(posedge sclk);
        #1;
        chk("resume_e", {63'h0, e64}, 64'h1);
        chk("resume_d", d64, 64'h77);

        // Ack coincides with the timeout count: ack wins
        for (int k = 0; k < 5; k++) begin
            @(negedge sclk);
            if (k == 0) ctl(5'b00000, 3'b010, 5'd12, 1'b1, 1'b0, 1'b0);
            if (k == 4) begin
                dwb_ack = 1'b1; dti64 = 64'h0000_0000_0000_4321;
            end
            #1;
            chk($sformatf("race_stall%0d", k), {63'h0, st64}, {63'h0, (k < 4)});
            chk($sformatf("race_berr%0d", k), {63'h0, be64}, 64'h0);
            @(posedge sclk);
            #1;
        end
        chk("race_e", {63'h0, e64}, 64'h1);
        chk("race_d", d64, 64'h4321);

        // Reset in the middle of a wait
        for (int k = 0; k < 2; k++) begin
            @(negedge sclk);
            if (k == 0) ctl(5'b00000, 3'b010, 5'd13, 1'b1, 1'b0, 1'b0);
            #1;
            chk($sformatf("rw_stall%0d", k), {63'h0, st64}, 64'h1);
            @(posedge sclk);
        end
        @(negedge sclk);
        srst = 1'b1;
        @(posedge sclk);
        #1;
        chk("rw_e", {63'h0, e64}, 64'h0);
        @(negedge sclk);
        srst = 1'b0;
        idle();
        #1;
        chk("rw_stall_after", {63'h0, st64}, 64'h0);
        chk("rw_berr_after", {63'h0, be64}, 64'h0);
        @(posedge sclk);
        #1;
        chk("rw_e_after", {63'h0, e64}, 64'h0);

        // Store timing out from a freshly reset counter: full wait, berr, no write
        for (int k = 0; k < 5; k++) begin
            @(negedge sclk);
            if (k == 0) ctl(5'b01000, 3'b010, 5'd14, 1'b1, 1'b1, 1'b0);
            #1;
            chk($sformatf("st_stall%0d", k), {63'h0, st64}, {63'h0, (k < 4)});
            chk($sformatf("st_berr%0d", k), {63'h0, be64}, {63'h0, (k == 4)});
            @(posedge sclk);
            #1;
            chk($sformatf("st_e%0d", k), {63'h0, e64}, 64'h0);
        end

        // sena low holds M; the held instruction writes once when re-enabled
        @(negedge sclk);
        ctl(5'b01100, 3'b000, 5'd15, 1'b0, 1'b0, 1'b0);
        alu64 = 64'h33;
        @(posedge sclk);
        #1;
        @(negedge sclk);
        sena = 1'b0;
        idle();
        alu64 = 64'h44;
        #1;
        chk("hold_e_off", {63'h0, e64}, 64'h0);
        @(posedge sclk);
        #1;
        chk("hold_d", d64, 64'h33);
        @(negedge sclk);
        sena = 1'b1;
        #1;
        chk("hold_e_on", {63'h0, e64}, 64'h1);
        chk("hold_a", {59'h0, a64}, 64'd15);
        @(posedge sclk);
        #1;
        chk("hold_e_once", {63'h0, e64}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
